// File: rtl/float_to_fixed_pkg.sv
// Shared types and helpers for the iterative float-to-fixed converter.
package float_to_fixed_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLASS,
        ST_SHIFT,
        ST_ROUND,
        ST_DONE
    } state_t;

    // Exponent bias for an EW-bit biased exponent.
    function automatic int bias_of(input int ew);
        return (1 << (ew - 1)) - 1;
    endfunction

    // Shift counter must hold the longest left shift (< W) and the
    // clipped right shift (MW+2).
    function automatic int cnt_width(input int w, input int mw);
        int m;
        m = (w > mw + 3) ? w : mw + 3;
        return $clog2(m);
    endfunction

endpackage

// File: rtl/float_to_fixed_iter_shift_round.sv
// Magnitude/guard/sticky shifter with the round, negate and saturate stage.
module fx_shift_round #(
    parameter int MW = 23,
    parameter int W  = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_load,
    input  logic [MW:0]   i_mag,
    input  logic          i_shift_en,
    input  logic          i_shift_left,
    input  logic          i_round,
    input  logic          i_sign,
    input  logic          i_rnd_mode,
    input  logic          i_special,
    input  logic          i_sp_sat,
    input  logic          i_sp_inv,
    output logic [W-1:0]  o_fixed,
    output logic          o_ovf,
    output logic          o_inv
);

    // Magnitude limits expressed in the widened rounding width.
    localparam logic [W+1:0] POS_LIM = {3'b000, {(W-1){1'b1}}};
    localparam logic [W+1:0] NEG_LIM = {3'b001, {(W-1){1'b0}}};

    logic [W:0]          r_mag;
    logic                r_guard;
    logic                r_sticky;
    logic [W+1:0]        w_rounded;
    logic signed [W+1:0] w_signed;
    logic                w_sat;

    // Round-to-nearest-even increment decision; truncation never increments.
    function automatic logic round_up(input logic rnd, input logic g,
                                      input logic s, input logic lsb);
        return rnd & g & (s | lsb);
    endfunction

    // Saturated output for the given sign.
    function automatic logic [W-1:0] sat_value(input logic neg);
        return neg ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    endfunction

    // Load the mantissa, then shift one bit per enabled cycle.
    always_ff @(posedge clk) begin
        if (i_load) begin
            r_mag    <= {{(W-MW){1'b0}}, i_mag};
            r_guard  <= 1'b0;
            r_sticky <= 1'b0;
        end else if (i_shift_en) begin
            if (i_shift_left) begin
                r_mag <= r_mag << 1;
            end else begin
                r_mag    <= r_mag >> 1;
                r_guard  <= r_mag[0];
                r_sticky <= r_sticky | r_guard;
            end
        end
    end

    // Round in a widened width so nothing wraps before the saturate check.
    always_comb begin
        w_rounded = {1'b0, r_mag} + (W+2)'(round_up(i_rnd_mode, r_guard, r_sticky, r_mag[0]));
        w_sat     = i_sign ? (w_rounded > NEG_LIM) : (w_rounded > POS_LIM);
        w_signed  = i_sign ? -$signed(w_rounded) : $signed(w_rounded);
    end

    // Result registers: written by either the special-value path or the round strobe.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            o_fixed <= '0;
            o_ovf   <= 1'b0;
            o_inv   <= 1'b0;
        end else if (i_special) begin
            o_fixed <= i_sp_sat ? sat_value(i_sign) : '0;
            o_ovf   <= i_sp_sat;
            o_inv   <= i_sp_inv;
        end else if (i_round) begin
            o_fixed <= w_sat ? sat_value(i_sign) : w_signed[W-1:0];
            o_ovf   <= w_sat;
            o_inv   <= 1'b0;
        end
    end

endmodule

// File: rtl/float_to_fixed_iter.sv
// Iterative floating-point to signed fixed-point converter with handshake.
module float_to_fixed_iter
    import float_to_fixed_pkg::*;
#(
    parameter int EW   = 8,
    parameter int MW   = 23,
    parameter int W    = 32,
    parameter int FRAC = 16
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             BEGIN_FSM,
    input  logic             RND_MODE,
    input  logic [EW+MW:0]   FLOAT_IN,
    output logic [W-1:0]     FIXED_OUT,
    output logic             ACK_FF,
    output logic             BUSY,
    output logic             OVF,
    output logic             INVALID
);

    localparam int BIAS = bias_of(EW);
    localparam int CW   = cnt_width(W, MW);

    state_t              r_state;
    state_t              w_next;
    logic                r_ack;
    logic                r_sign;
    logic [EW-1:0]       r_exp;
    logic [MW-1:0]       r_man;
    logic                r_rnd;
    logic [CW-1:0]       r_cnt;
    logic                r_left;

    logic signed [31:0]  w_d;
    logic signed [31:0]  w_nabs;
    logic [CW-1:0]       w_n;
    logic                w_ovf_early;
    logic                w_load;
    logic                w_shift_en;
    logic                w_round;
    logic                w_special;
    logic                w_sp_sat;
    logic                w_sp_inv;

    // Shift distance d = E - bias - MW + FRAC and its clipped magnitude.
    always_comb begin
        w_d         = $signed(32'(r_exp)) - 32'(BIAS + MW - FRAC);
        w_ovf_early = (w_d >= 32'(W - 1 - MW));
        w_nabs      = (w_d < 0) ? -w_d : w_d;
        if ((w_d < 0) && (w_nabs > 32'(MW + 2))) begin
            w_nabs = 32'(MW + 2);
        end
        w_n = CW'(w_nabs);
    end

    // State register and acknowledge flag; ACK is high while DONE is being held.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_state <= ST_IDLE;
            r_ack   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_ack   <= (r_state == ST_DONE) && (w_next == ST_DONE);
        end
    end

    // Operand capture in IDLE and shift counter bookkeeping.
    always_ff @(posedge CLK) begin
        if (r_state == ST_IDLE && BEGIN_FSM) begin
            r_sign <= FLOAT_IN[EW+MW];
            r_exp  <= FLOAT_IN[EW+MW-1:MW];
            r_man  <= FLOAT_IN[MW-1:0];
            r_rnd  <= RND_MODE;
        end
        if (r_state == ST_CLASS) begin
            r_cnt  <= w_n;
            r_left <= ~w_d[31];
        end else if (r_state == ST_SHIFT) begin
            r_cnt  <= r_cnt - 1'b1;
        end
    end

    // Next-state and datapath strobes.
    always_comb begin
        w_next     = r_state;
        w_load     = 1'b0;
        w_shift_en = 1'b0;
        w_round    = 1'b0;
        w_special  = 1'b0;
        w_sp_sat   = 1'b0;
        w_sp_inv   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (BEGIN_FSM) w_next = ST_CLASS;
            end
            ST_CLASS: begin
                w_load = 1'b1;
                if (r_exp == '0) begin
                    w_special = 1'b1;
                    w_next    = ST_DONE;
                end else if (&r_exp) begin
                    w_special = 1'b1;
                    w_sp_inv  = |r_man;
                    w_sp_sat  = ~|r_man;
                    w_next    = ST_DONE;
                end else if (w_ovf_early) begin
                    w_special = 1'b1;
                    w_sp_sat  = 1'b1;
                    w_next    = ST_DONE;
                end else begin
                    w_next = (w_n != '0) ? ST_SHIFT : ST_ROUND;
                end
            end
            ST_SHIFT: begin
                w_shift_en = 1'b1;
                if (r_cnt == CW'(1)) w_next = ST_ROUND;
            end
            ST_ROUND: begin
                w_round = 1'b1;
                w_next  = ST_DONE;
            end
            ST_DONE: begin
                if (!BEGIN_FSM) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    fx_shift_round #(
        .MW (MW),
        .W  (W)
    ) u_shift_round (
        .clk          (CLK),
        .rst_n        (RST_N),
        .i_load       (w_load),
        .i_mag        ({1'b1, r_man}),
        .i_shift_en   (w_shift_en),
        .i_shift_left (r_left),
        .i_round      (w_round),
        .i_sign       (r_sign),
        .i_rnd_mode   (r_rnd),
        .i_special    (w_special),
        .i_sp_sat     (w_sp_sat),
        .i_sp_inv     (w_sp_inv),
        .o_fixed      (FIXED_OUT),
        .o_ovf        (OVF),
        .o_inv        (INVALID)
    );

    assign ACK_FF = r_ack;
    assign BUSY   = (r_state != ST_IDLE);

endmodule

// File: tb/tb_float_to_fixed_iter.sv
// Randomised and directed bench for float_to_fixed_iter against a value-level model.
module tb_float_to_fixed_iter;

    localparam int EW   = 8;
    localparam int MW   = 23;
    localparam int W    = 32;
    localparam int FRAC = 16;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        BEGIN_FSM = 1'b0;
    logic        RND_MODE = 1'b0;
    logic [31:0] FLOAT_IN = '0;
    logic [31:0] FIXED_OUT;
    logic        ACK_FF;
    logic        BUSY;
    logic        OVF;
    logic        INVALID;

    int n_checks = 0;
    int n_err    = 0;

    logic        chk_en = 1'b0;
    logic [31:0] exp_fx;
    logic        exp_ovf;
    logic        exp_inv;

    float_to_fixed_iter #(
        .EW   (EW),
        .MW   (MW),
        .W    (W),
        .FRAC (FRAC)
    ) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .BEGIN_FSM (BEGIN_FSM),
        .RND_MODE  (RND_MODE),
        .FLOAT_IN  (FLOAT_IN),
        .FIXED_OUT (FIXED_OUT),
        .ACK_FF    (ACK_FF),
        .BUSY      (BUSY),
        .OVF       (OVF),
        .INVALID   (INVALID)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: real-number meaning of the float scaled by 2^FRAC, with
    // rounding decided by comparing the discarded remainder against one half.
    task automatic model(input logic [31:0] f, input logic rnd,
                         output logic [31:0] fx, output logic ovf,
                         output logic inv, output int lat);
        int     e, d, n;
        longint m, mag, q, rem, half;
        logic   s;
        s   = f[31];
        e   = int'(f[30:23]);
        m   = longint'(f[22:0]) + (longint'(1) << MW);
        fx  = '0; ovf = 1'b0; inv = 1'b0; lat = 2; mag = 0;
        if (e == 0) begin
            fx = '0;
        end else if (e == 255) begin
            if (f[22:0] != 0) inv = 1'b1;
            else begin
                ovf = 1'b1;
                fx  = s ? 32'h8000_0000 : 32'h7FFF_FFFF;
            end
        end else begin
            d = e - 127 - MW + FRAC;
            if (MW + d >= W - 1) begin
                ovf = 1'b1;
                fx  = s ? 32'h8000_0000 : 32'h7FFF_FFFF;
            end else begin
                if (d >= 0) begin
                    mag = m << d;
                    lat = 3 + d;
                end else begin
                    n   = -d;
                    lat = 3 + ((n > MW + 2) ? MW + 2 : n);
                    if (n > 40) n = 40;
                    q    = m >> n;
                    rem  = m - (q << n);
                    half = longint'(1) << (n - 1);
                    mag  = q;
                    if (rnd && (rem > half || (rem == half && q[0]))) mag = q + 1;
                end
                if (!s && mag > 64'h7FFF_FFFF) begin
                    ovf = 1'b1; fx = 32'h7FFF_FFFF;
                end else if (s && mag > 64'h8000_0000) begin
                    ovf = 1'b1; fx = 32'h8000_0000;
                end else begin
                    fx = s ? 32'(-mag) : 32'(mag);
                end
            end
        end
    endtask

    // Compare DUT result against the model on every cycle the result is acknowledged.
    always @(negedge CLK) begin
        if (chk_en && ACK_FF) begin
            check("fixed_out", 64'(FIXED_OUT), 64'(exp_fx));
            check("ovf", 64'(OVF), 64'(exp_ovf));
            check("invalid", 64'(INVALID), 64'(exp_inv));
        end
    end

    task automatic run_conv(input logic [31:0] f, input logic rnd,
                            input bit toggle, input int hold);
        int   lat, cnt;
        bit   got;
        logic [31:0] fx;
        logic ovf, inv;
        model(f, rnd, fx, ovf, inv, lat);
        exp_fx  = fx;
        exp_ovf = ovf;
        exp_inv = inv;
        chk_en  = 1'b1;
        if (lat < 6) toggle = 1'b0;
        FLOAT_IN  = f;
        RND_MODE  = rnd;
        BEGIN_FSM = 1'b1;
        cnt = -1;
        got = 1'b0;
        while (!got && cnt < 100) begin
            @(posedge CLK); #1;
            cnt++;
            if (cnt == 0) continue;
            if (ACK_FF) got = 1'b1;
            else begin
                check("busy_during", 64'(BUSY), 64'd1);
                if (toggle && cnt <= 4) begin
                    BEGIN_FSM = ~BEGIN_FSM;
                    FLOAT_IN  = $urandom;
                    RND_MODE  = ~RND_MODE;
                end else begin
                    BEGIN_FSM = 1'b1;
                end
            end
        end
        check("ack_seen", 64'(got), 64'd1);
        check("latency", 64'(cnt), 64'(lat));
        for (int h = 0; h < hold; h++) begin
            @(posedge CLK); #1;
            check("ack_hold", 64'(ACK_FF), 64'd1);
        end
        BEGIN_FSM = 1'b0;
        @(posedge CLK); #1;
        check("ack_drop", 64'(ACK_FF), 64'd0);
        check("busy_drop", 64'(BUSY), 64'd0);
    endtask

    task automatic directed(input logic [31:0] f, input logic rnd,
                            input logic [31:0] lfx, input logic lovf,
                            input logic linv, input int llat);
        logic [31:0] fx;
        logic ovf, inv;
        int lat;
        model(f, rnd, fx, ovf, inv, lat);
        check("model_fx", 64'(fx), 64'(lfx));
        check("model_ovf", 64'(ovf), 64'(lovf));
        check("model_inv", 64'(inv), 64'(linv));
        check("model_lat", 64'(lat), 64'(llat));
        run_conv(f, rnd, 1'b0, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    initial begin
        RST_N = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check("rst_fixed", 64'(FIXED_OUT), 64'd0);
        check("rst_ack", 64'(ACK_FF), 64'd0);
        check("rst_busy", 64'(BUSY), 64'd0);
        check("rst_ovf", 64'(OVF), 64'd0);
        check("rst_inv", 64'(INVALID), 64'd0);
        RST_N = 1'b1;
        @(posedge CLK); #1;

        directed(32'h3F80_0000, 1'b0, 32'h0001_0000, 1'b0, 1'b0, 10);
        directed(32'hC020_0000, 1'b0, 32'hFFFD_8000, 1'b0, 1'b0, 9);
        directed(32'h3740_0000, 1'b1, 32'h0000_0001, 1'b0, 1'b0, 27);
        directed(32'h3740_0000, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 27);
        directed(32'h3700_0000, 1'b1, 32'h0000_0000, 1'b0, 1'b0, 27);
        directed(32'h4780_0000, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b0, 2);
        directed(32'h7FC0_0000, 1'b0, 32'h0000_0000, 1'b0, 1'b1, 2);
        directed(32'h0000_0000, 1'b1, 32'h0000_0000, 1'b0, 1'b0, 2);
        directed(32'h0000_0001, 1'b1, 32'h0000_0000, 1'b0, 1'b0, 2);
        directed(32'hFF80_0000, 1'b0, 32'h8000_0000, 1'b1, 1'b0, 2);

        // BEGIN/FLOAT_IN/RND_MODE wiggling mid-conversion, long hold in DONE.
        run_conv(32'h3F80_0000, 1'b0, 1'b1, 4);

        // Reset in the middle of a shift sequence, with -inf result still on the outputs.
        run_conv(32'hFF80_0000, 1'b0, 1'b0, 0);
        FLOAT_IN  = 32'h3F80_0000;
        RND_MODE  = 1'b0;
        BEGIN_FSM = 1'b1;
        repeat (4) @(posedge CLK);
        #1;
        check("mid_busy", 64'(BUSY), 64'd1);
        RST_N     = 1'b0;
        BEGIN_FSM = 1'b0;
        @(posedge CLK); #1;
        check("mrst_fixed", 64'(FIXED_OUT), 64'd0);
        check("mrst_ack", 64'(ACK_FF), 64'd0);
        check("mrst_busy", 64'(BUSY), 64'd0);
        check("mrst_ovf", 64'(OVF), 64'd0);
        check("mrst_inv", 64'(INVALID), 64'd0);
        RST_N = 1'b1;
        @(posedge CLK); #1;
        run_conv(32'h3F80_0000, 1'b0, 1'b0, 1);

        for (int i = 0; i < 150; i++) begin
            logic [31:0] f;
            int r;
            r = int'($urandom_range(0, 19));
            f = $urandom;
            if (r == 0)      f[30:23] = 8'd0;
            else if (r == 1) f[30:23] = 8'hFF;
            else if (r == 2) begin f[30:23] = 8'hFF; f[22:0] = '0; end
            else             f[30:23] = 8'($urandom_range(95, 150));
            if (r == 3) f[15:0] = 16'h0000;
            run_conv(f, 1'($urandom), (i % 10) == 0, int'($urandom_range(0, 2)));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
